// File: rtl/ysyx_23060187_ifu.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060187_ifu
//  Description : Instruction fetch unit. Takes one PC per handshake, issues an
//                AXI4-Lite-style AR/R read and hands inst/PC/fault to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060187_ifu #(
    parameter logic [31:0] RESET_INST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic        inst_valid,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_fault_q, inst_fault_d;
    logic        inst_valid_q, inst_valid_d;
    logic        drop_q, drop_d;

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;
        drop_d       = drop_q;

        case (state_q)
            S_IDLE: begin
                if (pc_valid) begin
                    araddr_d  = pc_in;
                    inst_pc_d = pc_in;
                    if (pc_in[1:0] != 2'b00) begin
                        inst_d       = RESET_INST;
                        inst_fault_d = 1'b1;
                        state_d      = S_OUT;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AR: begin
                // The address phase is never withdrawn; a flush only marks the beat for discard.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (rvalid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        inst_d       = rdata;
                        inst_fault_d = (rresp != 2'b00);
                        state_d      = S_OUT;
                    end
                end
            end
            S_OUT: begin
                // A flush wins over a coincident inst_ready: no transfer happens.
                if (flush || inst_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        arvalid_d    = (state_d == S_AR);
        rready_d     = (state_d == S_R);
        inst_valid_d = (state_d == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            araddr_q     <= 32'h0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_q       <= RESET_INST;
            inst_pc_q    <= 32'h0;
            inst_fault_q <= 1'b0;
            inst_valid_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
            inst_valid_q <= inst_valid_d;
            drop_q       <= drop_d;
        end
    end

    assign pc_ready   = (state_q == S_IDLE);
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_fault = inst_fault_q;
    assign inst_valid = inst_valid_q;

endmodule
`default_nettype wire

// File: doc/ysyx_23060187_ifu.md
# ysyx_23060187_ifu

Instruction fetch unit placed directly downstream of the PC register. It accepts one fetch address per handshake and issues an AXI4-Lite-style read (AR/R channels) to instruction memory. It presents the returned instruction, together with its PC, to decode over a valid/ready handshake. A flush input squashes any in-flight fetch when the back end redirects the PC.

## Interface
Parameters:
- RESET_INST, 32'h00000000, value held on `inst` after reset and on fault.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_in  in  32  fetch address from the PC register.
- pc_valid  in  1  `pc_in` is valid.
- pc_ready  out  1  IFU can accept a PC. Equals (state==IDLE); the PC register advances only on `pc_valid && pc_ready`.
- flush  in  1  redirect; squash the current fetch.
- araddr  out  32  read address (registered).
- arvalid  out  1  read address valid.
- arready  in  1  memory accepts the address.
- rdata  in  32  read data.
- rresp  in  2  read response; any value other than 2'b00 is an error.
- rvalid  in  1  read data valid.
- rready  out  1  IFU accepts read data.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of `inst`.
- inst_fault  out  1  fetch fault: misaligned PC or bus error.
- inst_valid  out  1  `inst`, `inst_pc` and `inst_fault` are valid.
- inst_ready  in  1  decode consumes the instruction.

## Operation
- FSM states: IDLE, AR, R, OUT. A `drop` flag marks a squashed fetch.
- **IDLE:** on `pc_valid`, latch `pc_in` into `araddr` and `inst_pc`.
  - If `pc_in[1:0]!=0`: go to OUT with `inst=RESET_INST`, `inst_fault=1`. No bus request is made.
  - Otherwise: go to AR.
- **AR:** `arvalid=1`, with `araddr` stable until `arready`. On `arready`, go to R.
- **R:** `rready=1`. On `rvalid`:
  - If `drop`: clear `drop` and go to IDLE. Data is discarded.
  - Otherwise: register `inst=rdata`, `inst_fault=(rresp!=0)`, and go to OUT.
- **OUT:** `inst_valid=1`, with all outputs stable until `inst_ready`. On `inst_ready`, go to IDLE.
- **Flush:**
  - In IDLE: no effect. A coincident `pc_valid` is accepted normally.
  - In AR: `arvalid` is not withdrawn. Set `drop`, complete the AR handshake, then discard the R beat.
  - In R: set `drop`. If `rvalid` arrives in the same cycle, discard that beat and go to IDLE.
  - In OUT: drop `inst_valid` and go to IDLE. A coincident `inst_ready` does not count as a transfer.
- A `rresp` error does not retry. The fault is reported to decode.
- `araddr` is the full 32-bit PC. No address translation or wrap handling is done; 32'hFFFFFFFC is a legal address.

## Timing
- Reset values: state=IDLE, `arvalid=0`, `rready=0`, `inst_valid=0`, `inst=RESET_INST`, `inst_pc=0`, `inst_fault=0`, `araddr=0`, `drop=0`. `pc_ready=1` after reset.
- Reset asserted mid-fetch returns to IDLE immediately and drops `arvalid`, `rready` and `inst_valid` asynchronously.
- All outputs are registered except `pc_ready`, which is decoded from state.
- Minimum latency, counting the PC accept as cycle 0:
  - `arvalid` high in cycle 1.
  - With `arready` in cycle 1, `rready` is high in cycle 2.
  - With `rvalid` in cycle 2, `inst_valid` is high in cycle 3.
- Misaligned PC: `inst_valid` is high in cycle 1.
- Throughput: at most one instruction per 4 cycles. There is one IDLE cycle after each OUT handshake.
- Memory wait states extend AR and R indefinitely. Decode back-pressure extends OUT indefinitely.

## Test plan
- **Basic fetch:** `pc_in=32'h80000000`, `arready=1` immediately, `rdata=32'h00000297`, `rresp=0` one cycle later. Required: `inst_valid` in cycle 3 with `inst=32'h00000297`, `inst_pc=32'h80000000`, `inst_fault=0`; `pc_ready` high again after `inst_ready`.
- **Wait states and back-pressure:** `arready` delayed 3 cycles, `rvalid` delayed 2 cycles, `inst_ready` delayed 4 cycles. Required: `araddr` stable while `arvalid` is high; `inst` and `inst_pc` stable while `inst_valid` is high.
- **Misaligned PC:** `pc_in=32'h80000002`. Required: no `arvalid`; `inst_valid` in cycle 1 with `inst_fault=1` and `inst=RESET_INST`.
- **Bus error:** `rresp=2'b10`. Required: `inst_fault=1` and `inst=rdata`.
- **Flush:**
  - Flush during AR: the AR handshake still completes, the R beat is consumed, and no `inst_valid` follows.
  - Flush during OUT: `inst_valid` drops next cycle.
  - Flush coincident with `pc_valid` in IDLE: the new PC is accepted.
- **Reset:** assert `rst_n=0` while in R. Required: all outputs at their reset values immediately; the next fetch after release behaves normally.
